cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among the functional units of the out-of-order core: integer ALU, multiplier, divider and load/store.

- Each unit deposits one completed result (tag + data) into a private one-entry holding slot.
- The arbiter selects one slot per cycle and drives the registered CDB broadcast.
- The register status table, reservation stations and register file all consume that broadcast.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 37 +++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | cdb_arbiter_pkg : core-wide result-bus sizing and requester ids     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cdb_arbiter_pkg;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  // Fixed requester mapping onto the CDB arbiter ports.
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MUL = 2'd1,
    REQ_DIV = 2'd2,
    REQ_LS  = 2'd3
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, search starts at ptr   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand   = '0;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    // Walk ptr, ptr+1, ... with wrap; the first requesting slot wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +--------------------------------------------------------------------+
// | cdb_arbiter : per-unit holding slots feeding a registered CDB       |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter #(
  parameter int NREQ   = cdb_arbiter_pkg::NREQ,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [$clog2(NREQ)-1:0]  cdb_src
);

  import cdb_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]             slot_valid_q, slot_valid_d;
  logic [NREQ-1:0][TAG_W-1:0]  slot_tag_q,   slot_tag_d;
  logic [NREQ-1:0][DATA_W-1:0] slot_data_q,  slot_data_d;
  logic [IDX_W-1:0]            ptr_q,        ptr_d;
  logic                        cdb_valid_q,  cdb_valid_d;
  logic [TAG_W-1:0]            cdb_tag_q,    cdb_tag_d;
  logic [DATA_W-1:0]           cdb_data_q,   cdb_data_d;
  logic [IDX_W-1:0]            cdb_src_q,    cdb_src_d;

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  xfer;
  logic [IDX_W-1:0] winner;
  logic             any_valid;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (slot_valid_q),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner),
    .any    (any_valid)
  );

  // A slot being granted this cycle can take a new result: grant-and-refill.
  assign req_ready = flush ? '0 : (~slot_valid_q | grant);
  assign xfer      = req_valid & req_ready;

  always_comb begin
    slot_tag_d  = slot_tag_q;
    slot_data_d = slot_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) begin
        slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
        slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    slot_valid_d = (slot_valid_q & ~grant) | xfer;
    ptr_d        = ptr_q;
    cdb_valid_d  = any_valid;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    if (flush) begin
      slot_valid_d = '0;
      ptr_d        = '0;
      cdb_valid_d  = 1'b0;
    end else if (any_valid) begin
      ptr_d      = (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      cdb_tag_d  = slot_tag_q[winner];
      cdb_data_d = slot_data_q[winner];
      cdb_src_d  = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_tag_q   <= '0;
      slot_data_q  <= '0;
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_tag_q   <= slot_tag_d;
      slot_data_q  <= slot_data_d;
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_cdb_arbiter : scenario tasks plus randomized run vs. a model     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cdb_arbiter;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;

  int total = 0;
  int bad   = 0;

  // Behavioural model: held results per unit, rotating start index, bus copy.
  logic [NREQ-1:0]   m_valid;
  logic [TAG_W-1:0]  m_tag  [NREQ];
  logic [DATA_W-1:0] m_data [NREQ];
  int                m_ptr;
  logic              m_cv;
  logic [TAG_W-1:0]  m_ct;
  logic [DATA_W-1:0] m_cd;
  logic [1:0]        m_cs;

  cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (m_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    int w;
    w = model_winner();
    for (int i = 0; i < NREQ; i++) r[i] = !flush && (!m_valid[i] || w == i);
    return r;
  endfunction

  task automatic drive(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // One clock: advance the model with the inputs seen at the edge, return at negedge.
  task automatic tick();
    logic [NREQ-1:0] rdy;
    int w;
    rdy = model_ready();
    w   = model_winner();
    @(posedge clk);
    if (rst) begin
      m_valid = '0; m_ptr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0; m_cs = '0;
    end else if (flush) begin
      m_valid = '0; m_ptr = 0; m_cv = 1'b0;
    end else begin
      m_cv = (w >= 0);
      if (w >= 0) begin
        m_ct = m_tag[w]; m_cd = m_data[w]; m_cs = w[1:0];
        m_ptr = (w + 1) % NREQ;
        m_valid[w] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && rdy[i]) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = req_tag[i*TAG_W +: TAG_W];
          m_data[i]  = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got=%b exp=1111", req_ready); end
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
    total++; if (cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0)
      begin bad++; $display("FAIL reset_bus got tag=%h data=%h src=%0d exp all zero", cdb_tag, cdb_data, cdb_src); end
  endtask

  task automatic test_single();
    drive(2, 1'b1, 6'h15, 32'hDEADBEEF);
    tick();
    drive(2, 1'b0, 6'h00, 32'h0);
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", cdb_valid); end
    tick();
    total++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'h15 || cdb_src !== 2'd2 || cdb_data !== 32'hDEADBEEF)
      begin bad++; $display("FAIL single_bcast got v=%b tag=%h src=%0d data=%h exp 1/15/2/deadbeef", cdb_valid, cdb_tag, cdb_src, cdb_data); end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, TAG_W'(i + 1), $urandom);
    tick();
    req_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      total++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(k) || cdb_tag !== TAG_W'(k + 1) || cdb_data !== m_cd)
        begin bad++; $display("FAIL rr_order k=%0d got v=%b src=%0d tag=%0d exp v=1 src=%0d tag=%0d", k, cdb_valid, cdb_src, cdb_tag, k, k + 1); end
    end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        drive(1, 1'b1, TAG_W'(10 + k), 32'h1000 + k);
        #1;
        total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, req_ready[1]); end
      end else begin
        drive(1, 1'b0, '0, '0);
      end
      tick();
      if (k >= 1) begin
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(10 + k - 1) || cdb_src !== 2'd1)
          begin bad++; $display("FAIL b2b_bus k=%0d got v=%b tag=%0d src=%0d exp v=1 tag=%0d src=1", k, cdb_valid, cdb_tag, cdb_src, 10 + k - 1); end
      end
    end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_stall();
    int nxt0, nxt3, exp0, exp3, prev;
    logic [NREQ-1:0] exp_rdy;
    rst = 1'b1; tick(); rst = 1'b0;
    nxt0 = 32; nxt3 = 48; exp0 = 32; exp3 = 48; prev = -1;
    for (int c = 0; c < 12; c++) begin
      drive(0, 1'b1, TAG_W'(nxt0), 32'hA000 + nxt0);
      drive(3, 1'b1, TAG_W'(nxt3), 32'hB000 + nxt3);
      #1;
      exp_rdy = model_ready();
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (m_valid[3] && model_winner() != 3) begin
        total++; if (req_ready[3] !== 1'b0) begin bad++; $display("FAIL stall_bp3 c=%0d got=%b exp=0", c, req_ready[3]); end
      end
      tick();
      if (exp_rdy[0]) nxt0++;
      if (exp_rdy[3]) nxt3++;
      if (cdb_valid === 1'b1) begin
        total++;
        if (cdb_src == 2'd0 ? (cdb_tag !== TAG_W'(exp0) || cdb_data !== 32'hA000 + exp0)
                            : (cdb_src !== 2'd3 || cdb_tag !== TAG_W'(exp3) || cdb_data !== 32'hB000 + exp3))
          begin bad++; $display("FAIL stall_seq c=%0d got src=%0d tag=%0d exp0=%0d exp3=%0d", c, cdb_src, cdb_tag, exp0, exp3); end
        if (cdb_src == 2'd0) exp0++; else exp3++;
        if (prev >= 0) begin
          total++; if (int'(cdb_src) == prev) begin bad++; $display("FAIL stall_alt c=%0d got src=%0d exp not %0d", c, cdb_src, prev); end
        end
        prev = int'(cdb_src);
      end
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_flush();
    rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 1'b1, 6'd20, 32'h20);
    drive(1, 1'b1, 6'd21, 32'h21);
    drive(2, 1'b1, 6'd22, 32'h22);
    tick();
    req_valid = '0;
    drive(3, 1'b1, 6'd30, 32'h30);
    flush = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
    tick();
    flush = 1'b0;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", cdb_valid); end
    #1;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL flush_ready_after got=%b exp=1111", req_ready); end
    tick();
    drive(3, 1'b0, '0, '0);
    tick();
    total++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd30 || cdb_src !== 2'd3)
      begin bad++; $display("FAIL flush_next got v=%b tag=%0d src=%0d exp v=1 tag=30 src=3", cdb_valid, cdb_tag, cdb_src); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_stale k=%0d got v=%b tag=%0d exp v=0", k, cdb_valid, cdb_tag); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, TAG_W'(40 + i), $urandom);
    tick();
    req_valid = '0;
    tick();
    total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", cdb_valid); end
    rst = 1'b1;
    tick();
    total++; if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0)
      begin bad++; $display("FAIL rstmid_bus got v=%b tag=%h data=%h src=%0d exp all zero", cdb_valid, cdb_tag, cdb_data, cdb_src); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL rstmid_ready got=%b exp=1111", req_ready); end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_rdy;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
          pend[i] = 1'b1;
          drive(i, 1'b1, TAG_W'($urandom), $urandom);
        end
        req_valid[i] = pend[i];
      end
      flush = ($urandom_range(0, 99) < 4);
      #1;
      exp_rdy = model_ready();
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      tick();
      pend = pend & ~(exp_rdy & req_valid);
      total++; if (cdb_valid !== m_cv || cdb_tag !== m_ct || cdb_data !== m_cd || cdb_src !== m_cs)
        begin bad++; $display("FAIL rand_bus c=%0d got v=%b tag=%h data=%h src=%0d exp v=%b tag=%h data=%h src=%0d",
                              c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_cv, m_ct, m_cd, m_cs); end
    end
    flush = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    m_valid = '0; m_ptr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0; m_cs = '0;
    for (int i = 0; i < NREQ; i++) begin m_tag[i] = '0; m_data[i] = '0; end
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
